// File: rtl/asteroids_spawner.sv
// Asteroid special-stage spawner: per-slot launch/hit/hold control, hit counting and stage completion.
// Optional ASTEROIDS_SPAWN_JITTER_EN adds LFSR-jittered spawn reloads and an internal missCount.

module asteroids_spawner_slot #(
  parameter int HOLD = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_park,
  input  logic i_launch,
  input  logic i_hitRise,
  input  logic i_sof,
  output logic o_free,
  output logic o_live,
  output logic o_hit,
  output logic o_resetN,
  output logic o_active
);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD + 1) : 1;

  typedef enum logic [1:0] {S_FREE, S_LIVE, S_HIT} slot_t;

  slot_t         r_state, w_stateNext;
  logic [HW-1:0] r_hold, w_holdNext;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_FREE;
      r_hold  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_hold  <= w_holdNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_holdNext  = r_hold;
    case (r_state)
      S_FREE: if (i_launch) w_stateNext = S_LIVE;
      S_LIVE: if (i_hitRise) begin
        w_stateNext = S_HIT;
        w_holdNext  = HW'(HOLD);
      end
      S_HIT: if (i_sof) begin
        if (r_hold <= HW'(1)) begin
          w_stateNext = S_FREE;
          w_holdNext  = '0;
        end else begin
          w_holdNext = r_hold - HW'(1);
        end
      end
      default: w_stateNext = S_FREE;
    endcase
    if (i_park) begin
      w_stateNext = S_FREE;
      w_holdNext  = '0;
    end
  end

  // Mover stays out of reset through the hold so it keeps its stopped position.
  assign o_free   = (r_state == S_FREE);
  assign o_live   = (r_state == S_LIVE);
  assign o_hit    = (r_state == S_HIT);
  assign o_resetN = (r_state != S_FREE);
  assign o_active = (r_state == S_LIVE);
endmodule

module asteroids_spawner #(
  parameter int NUM_ASTEROIDS   = 4,
  parameter int SPAWN_INTERVAL  = 45,
  parameter int HITS_TO_WIN     = 10,
  parameter int HIT_HOLD_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     stageEnable,
  input  logic [NUM_ASTEROIDS-1:0] asteroidIsHit,
  input  logic [NUM_ASTEROIDS-1:0] asteroidWrapped,
  output logic [NUM_ASTEROIDS-1:0] slotResetN,
  output logic [NUM_ASTEROIDS-1:0] slotActive,
  output logic [7:0]               hitsCount,
  output logic                     stageDone
);
  localparam int N  = NUM_ASTEROIDS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [8:0]  WIN9 = 9'(HITS_TO_WIN);
  localparam logic [15:0] BASE = 16'(SPAWN_INTERVAL);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} st_t;

  st_t           r_state, w_stateNext;
  logic [15:0]   r_frameCnt, r_lfsr, w_lfsrNext, w_reload;
  logic [PW-1:0] r_ptr, w_sel;
  logic [7:0]    r_hits, w_hitsSat;
  logic [N-1:0]  r_hitPrev, w_rise, w_launch, w_free, w_live, w_hitSt;
  logic [3:0]    w_hitAdd;
  logic [8:0]    w_hitSum;
  logic          w_found, w_expire, w_doLaunch, w_win, w_park;

  // Fibonacci LFSR, taps 16/14/13/11.
  assign w_lfsrNext = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

`ifdef ASTEROIDS_SPAWN_JITTER_EN
  logic [7:0] r_missCount;
  logic [3:0] w_missAdd;

  assign w_reload = BASE + {12'd0, r_lfsr[3:0]};

  always_comb begin
    w_missAdd = '0;
    for (int k = 0; k < N; k++) w_missAdd = w_missAdd + {3'd0, asteroidWrapped[k] & w_live[k]};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_missCount <= '0;
    else         r_missCount <= r_missCount + {4'd0, w_missAdd};
  end
`else
  logic w_unusedWrap;

  assign w_reload     = BASE;
  assign w_unusedWrap = ^asteroidWrapped;
`endif

  // Only edges on LIVE slots are real hits; stale flags on parked slots are ignored.
  assign w_rise = asteroidIsHit & ~r_hitPrev & w_live;

  always_comb begin
    w_hitAdd = '0;
    for (int k = 0; k < N; k++) w_hitAdd = w_hitAdd + {3'd0, w_rise[k]};
  end

  assign w_hitSum  = {1'b0, r_hits} + {5'd0, w_hitAdd};
  assign w_hitsSat = (w_hitSum >= WIN9) ? WIN9[7:0] : w_hitSum[7:0];
  assign w_win     = (w_hitsSat == WIN9[7:0]);

  // Round-robin pick: first FREE slot at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_free[(int'(r_ptr) + k) % N]) begin
        w_found = 1'b1;
        w_sel   = PW'((int'(r_ptr) + k) % N);
      end
    end
  end

  // Expiry is either the decrement to zero on this frame or a counter already parked at zero.
  assign w_expire   = (r_frameCnt == 16'd0) || (startOfFrame && r_frameCnt == 16'd1);
  assign w_doLaunch = (r_state == RUN) && stageEnable && w_expire && w_found && !w_win;
  assign w_launch   = w_doLaunch ? (N'(1) << w_sel) : '0;

  always_comb begin
    w_stateNext = r_state;
    w_park      = 1'b0;
    case (r_state)
      IDLE: begin
        w_park = 1'b1;
        if (stageEnable) w_stateNext = RUN;
      end
      RUN: begin
        if (!stageEnable) begin
          w_park      = 1'b1;
          w_stateNext = IDLE;
        end else if (w_win) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (!stageEnable) begin
          w_park      = 1'b1;
          w_stateNext = IDLE;
        end else if (w_hitSt == '0) begin
          w_park      = 1'b1;
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_park = 1'b1;
        if (!stageEnable) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_frameCnt <= '0;
      r_lfsr     <= 16'hACE1;
      r_ptr      <= '0;
      r_hits     <= '0;
      r_hitPrev  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_hitPrev <= asteroidIsHit;
      if (startOfFrame) r_lfsr <= w_lfsrNext;

      if (r_state == IDLE)       r_frameCnt <= stageEnable ? w_reload : 16'd0;
      else if (!stageEnable)     r_frameCnt <= 16'd0;
      else if (w_doLaunch)       r_frameCnt <= w_reload;
      else if (r_state == RUN && startOfFrame && r_frameCnt != 16'd0)
        r_frameCnt <= r_frameCnt - 16'd1;

      if (!stageEnable)                           r_hits <= '0;
      else if (r_state == RUN || r_state == DRAIN) r_hits <= w_hitsSat;

      if (!stageEnable)    r_ptr <= '0;
      else if (w_doLaunch) r_ptr <= PW'((int'(w_sel) + 1) % N);
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_slot
      asteroids_spawner_slot #(.HOLD(HIT_HOLD_FRAMES)) u_slot (
        .clk       (clk),
        .resetN    (resetN),
        .i_park    (w_park),
        .i_launch  (w_launch[g]),
        .i_hitRise (w_rise[g]),
        .i_sof     (startOfFrame),
        .o_free    (w_free[g]),
        .o_live    (w_live[g]),
        .o_hit     (w_hitSt[g]),
        .o_resetN  (slotResetN[g]),
        .o_active  (slotActive[g])
      );
    end
  endgenerate

  assign hitsCount = r_hits;
  assign stageDone = (r_state == DONE);
endmodule

// File: tb/tb_asteroids_spawner.sv
// Directed bench for asteroids_spawner (N=4, interval 3, win at 3 hits, hold 8) with an expectation queue.
module tb_asteroids_spawner;
  logic       clk = 1'b0;
  logic       resetN, sof, en;
  logic [3:0] hit, wrap, srn, act;
  logic [7:0] hits;
  logic       done;

  asteroids_spawner #(
    .NUM_ASTEROIDS(4), .SPAWN_INTERVAL(3), .HITS_TO_WIN(3), .HIT_HOLD_FRAMES(8)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .stageEnable(en),
    .asteroidIsHit(hit), .asteroidWrapped(wrap),
    .slotResetN(srn), .slotActive(act), .hitsCount(hits), .stageDone(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [7:0] obs(input int s);
    case (s)
      0:       return {4'd0, srn};
      1:       return {4'd0, act};
      2:       return hits;
      default: return {7'd0, done};
    endcase
  endfunction

  task automatic expect1(input string t, input int s, input logic [7:0] v);
    exp_t e;
    e.tag = t; e.sig = s; e.val = v;
    q.push_back(e);
  endtask

  task automatic expect4(input string t, input logic [3:0] r, input logic [3:0] a,
                         input logic [7:0] h, input logic d);
    expect1({t, ".slotResetN"}, 0, {4'd0, r});
    expect1({t, ".slotActive"}, 1, {4'd0, a});
    expect1({t, ".hitsCount"},  2, h);
    expect1({t, ".stageDone"},  3, {7'd0, d});
  endtask

  task automatic check_all();
    exp_t       e;
    logic [7:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sig);
      n_chk++;
      assert (o === e.val) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    sof = 1'b1; tick();
    sof = 1'b0; tick(); tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetN = 1'b0; en = 1'b1; sof = 1'b0; hit = '0; wrap = '0;
    #12;
    expect4("reset", 4'h0, 4'h0, 8'd0, 1'b0); check_all();
    @(negedge clk); resetN = 1'b1;
    tick();

    // stale hit flag on a parked slot must not count
    hit = 4'b1000;
    frames(2);
    expect4("pre_launch", 4'h0, 4'h0, 8'd0, 1'b0); check_all();
    hit = '0;
    frame();
    expect4("launch0", 4'h1, 4'h1, 8'd0, 1'b0); check_all();
    frames(3);
    expect1("launch1", 0, 8'h03); check_all();
    frames(3);
    expect1("launch2", 0, 8'h07); check_all();
    frames(3);
    expect4("all_live", 4'hF, 4'hF, 8'd0, 1'b0); check_all();

    wrap = 4'b0010; tick(); wrap = '0;
    expect4("wrap_no_change", 4'hF, 4'hF, 8'd0, 1'b0); check_all();

    hit = 4'b0100; tick();
    expect4("hit2", 4'hF, 4'hB, 8'd1, 1'b0); check_all();
    frames(7);
    expect4("hold2", 4'hF, 4'hB, 8'd1, 1'b0); check_all();
    sof = 1'b1; tick(); sof = 1'b0;
    expect4("free2", 4'hB, 4'hB, 8'd1, 1'b0); check_all();
    hit = '0;
    tick();
    expect4("relaunch2", 4'hF, 4'hF, 8'd1, 1'b0); check_all();
    tick();

    hit = 4'b1001; tick();
    expect4("double_hit", 4'hF, 4'h6, 8'd3, 1'b0); check_all();
    frames(7);
    expect4("drain_hold", 4'hF, 4'h6, 8'd3, 1'b0); check_all();
    sof = 1'b1; tick(); sof = 1'b0;
    expect4("drain_free", 4'h6, 4'h6, 8'd3, 1'b0); check_all();
    hit = '0;
    tick();
    expect4("done", 4'h0, 4'h0, 8'd3, 1'b1); check_all();
    tick();
    expect1("done_held", 3, 8'd1); check_all();
    en = 1'b0; tick();
    expect4("done_to_idle", 4'h0, 4'h0, 8'd0, 1'b0); check_all();

    en = 1'b1; tick();
    frames(3);
    expect1("rerun_launch0", 0, 8'h01); check_all();
    frames(6);
    expect4("three_live", 4'h7, 4'h7, 8'd0, 1'b0); check_all();
    en = 1'b0; tick();
    expect4("disable_mid_run", 4'h0, 4'h0, 8'd0, 1'b0); check_all();
    en = 1'b1; tick();
    frames(2);
    expect1("restart_wait", 0, 8'h00); check_all();
    frame();
    expect4("restart_launch", 4'h1, 4'h1, 8'd0, 1'b0); check_all();

    frames(6);
    expect1("refill", 0, 8'h07); check_all();
    hit = 4'b0111; tick();
    expect4("triple_hit", 4'h7, 4'h0, 8'd3, 1'b0); check_all();
    frame();
    @(negedge clk); resetN = 1'b0; #1;
    expect4("async_reset", 4'h0, 4'h0, 8'd0, 1'b0); check_all();
    hit = '0;
    #10;
    @(negedge clk); resetN = 1'b1;
    tick();
    frames(2);
    expect1("post_reset_wait", 0, 8'h00); check_all();
    frame();
    expect4("post_reset_launch", 4'h1, 4'h1, 8'd0, 1'b0); check_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/asteroids_spawner.md
Name: asteroids_spawner

Overview:
- Upstream controller for the asteroid special stage.
- Owns NUM_ASTEROIDS asteroid slots, one per downstream asteroid mover instance.
- Re-arms each mover through a per-slot active-low reset, and releases slots on a frame-counted schedule.
- Counts hits and detects stage completion; reports hit count and a done flag to the stage sequencer.

Parameters:
- NUM_ASTEROIDS, 4, number of slots and mover instances (1..8).
- SPAWN_INTERVAL, 45, frames between successive launches (>=1).
- HITS_TO_WIN, 10, destroyed asteroids needed to finish the stage (1..255).
- HIT_HOLD_FRAMES, 8, frames a hit slot stays parked before it becomes free.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- stageEnable  in  1  level; stage is running.
- asteroidIsHit  in  NUM_ASTEROIDS  per-slot sticky hit flag from the movers.
- asteroidWrapped  in  NUM_ASTEROIDS  per-slot one-cycle pulse when a mover returns to its start position after a border hit.
- slotResetN  out  NUM_ASTEROIDS  per-slot active-low reset to the movers; low = parked.
- slotActive  out  NUM_ASTEROIDS  slot is live and drawable.
- hitsCount  out  8  destroyed-asteroid count, saturating at HITS_TO_WIN.
- stageDone  out  1  level; high in DONE.

Behaviour:
- Reset values: slotResetN all 0; slotActive all 0; hitsCount 0; stageDone 0; frame counter 0; LFSR 16'hACE1; FSM IDLE; next-slot pointer 0.
- FSM states and transitions:
  - IDLE: all slots parked. When stageEnable=1 -> RUN, and frameCnt is loaded with SPAWN_INTERVAL.
  - RUN: on each startOfFrame, frameCnt decrements. When frameCnt reaches 0 and a FREE slot exists:
    - launch the lowest-index FREE slot at or after the pointer, wrapping round-robin;
    - slotResetN[i] and slotActive[i] go 1 in the next cycle;
    - the pointer advances to i+1 mod N;
    - frameCnt reloads.
  - RUN, no FREE slot at expiry: frameCnt holds 0 and the launch occurs on the first frame a slot frees.
  - At most one launch per frame.
- Per-slot state: FREE -> LIVE (launch) -> HIT (rising edge of asteroidIsHit while LIVE) -> FREE (after HIT_HOLD_FRAMES startOfFrame pulses).
  - Entering HIT drives slotActive[i]=0 on the next cycle.
  - slotResetN[i] stays 1 during the hold so the mover keeps its stopped position, then drops to 0 on return to FREE.
  - asteroidWrapped in LIVE: no state change; it is counted as a miss only in the optional feature.
- Hit counting:
  - Rising edges are detected from a registered copy of asteroidIsHit.
  - Multiple slots hit in the same cycle each count; the sum is added in one cycle and saturates at HITS_TO_WIN.
  - asteroidIsHit on a FREE slot is ignored.
- Completion: when hitsCount reaches HITS_TO_WIN -> DRAIN.
  - DRAIN: no new launches. Wait until no slot is in HIT, then park all slots (slotResetN=0, slotActive=0) -> DONE.
  - DONE: stageDone=1. Held until stageEnable=0 -> IDLE, which clears hitsCount, stageDone and the pointer.
- stageEnable dropping in RUN or DRAIN: next cycle, all slots are parked, counters are cleared, FSM -> IDLE.
- startOfFrame coincident with a hit on the same slot: the hit is taken first; that slot is not launched in this frame.
- The LFSR steps once per startOfFrame in every state, using polynomial x^16+x^14+x^13+x^11+1.

Optional Feature:
- ASTEROIDS_SPAWN_JITTER_EN defined:
  - each frameCnt reload value = SPAWN_INTERVAL + LFSR[3:0];
  - each asteroidWrapped pulse on a LIVE slot increments an 8-bit missCount, which is internal and observable by hierarchical reference;
  - stage behaviour is otherwise unchanged.
- Undefined: reload is exactly SPAWN_INTERVAL and missCount logic is absent.

Test Plan:
- Reset with stageEnable=1 and N=4, SPAWN_INTERVAL=3 -> first launch on slot 0 after the 3rd startOfFrame, then slots 1, 2, 3 every 3 frames; slotResetN=4'b1111 after 12 frames.
- All 4 LIVE, then hit slot 2 -> slotActive[2]=0 next cycle and hitsCount=1; slotResetN[2]=0 after 8 frames; slot 2 relaunched at the next expiry.
- asteroidIsHit rises on slots 0 and 3 in the same cycle -> hitsCount increments by 2 in one cycle.
- HITS_TO_WIN=2 and second hit lands -> no further launches; stageDone=1 once the HIT holds finish, all slotResetN=0; stageEnable=0 -> hitsCount=0, FSM IDLE.
- stageEnable deasserted mid-RUN with 3 slots LIVE -> next cycle all slotActive=0 and slotResetN=0; counter restarts from SPAWN_INTERVAL on re-enable.
- resetN pulsed low mid-DRAIN -> all outputs return to reset values asynchronously; with JITTER_EN, the reload after reset equals SPAWN_INTERVAL + (16'hACE1 stepped)[3:0].
